// File: rtl/circuit2_result_buffer_pkg.sv
// Shared constants and helpers for the circuit2 result buffer slice.
package circuit2_result_buffer_pkg;

  localparam int unsigned C2_DATAWIDTH = 32;
  localparam int unsigned C2_LAT       = 2;
  localparam int unsigned DROP_W       = 16;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/circuit2_result_buffer_valid_delay_line.sv
// LAT-deep shift register tracking operand validity through circuit2's pipeline.
module valid_delay_line #(
  parameter int unsigned LAT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic [LAT-1:0] vstage;

  generate
    if (LAT == 1) begin : g_one
      always_ff @(posedge Clk) begin
        if (Reset) vstage <= '0;
        else       vstage <= d;
      end
    end else begin : g_many
      always_ff @(posedge Clk) begin
        if (Reset) vstage <= '0;
        else       vstage <= {vstage[LAT-2:0], d};
      end
    end
  endgenerate

  assign q = vstage[LAT-1];

endmodule

// File: rtl/circuit2_result_buffer.sv
// Captures circuit2 z/x pairs when a tracked operand set emerges; FWFT FIFO drained by valid/ready.
module circuit2_result_buffer
  import circuit2_result_buffer_pkg::*;
#(
  parameter int unsigned DATAWIDTH = C2_DATAWIDTH,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LAT       = C2_LAT
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    op_valid,
  input  logic [DATAWIDTH-1:0]    z_in,
  input  logic [DATAWIDTH-1:0]    x_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATAWIDTH-1:0]    z_out,
  output logic [DATAWIDTH-1:0]    x_out,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [DATAWIDTH-1:0] mem_z [DEPTH];
  logic [DATAWIDTH-1:0] mem_x [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 cap;
  logic                 push;
  logic                 pop;

  valid_delay_line #(.LAT(LAT)) u_vdl (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (op_valid),
    .q     (cap)
  );

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the capture.
  assign push      = cap & (!full | pop);

  assign z_out = empty ? '0 : mem_z[rd_ptr];
  assign x_out = empty ? '0 : mem_x[rd_ptr];

  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      mem_z[wr_ptr] <= z_in;
      mem_x[wr_ptr] <= x_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (cap && !push) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_circuit2_result_buffer.sv
// Self-checking bench for circuit2_result_buffer: table vectors, corner sequences, random run vs queue model.
module tb_circuit2_result_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          op_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] z_in = '0;
  logic [DW-1:0] x_in = '0;
  logic          out_valid, full, empty, overflow;
  logic [DW-1:0] z_out, x_out;
  logic [3:0]    count;
  logic [15:0]   drop_cnt;

  always #5 Clk = ~Clk;

  circuit2_result_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .op_valid  (op_valid),
    .z_in      (z_in),
    .x_in      (x_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .z_out     (z_out),
    .x_out     (x_out),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // Operand set in flight: the edge at which its results are due, and the results.
  typedef struct {
    int            e;
    logic [DW-1:0] z;
    logic [DW-1:0] x;
  } op_t;

  op_t           due[$];
  logic [DW-1:0] mz[$];
  logic [DW-1:0] mx[$];
  bit            m_ovf = 1'b0;
  int            m_drops = 0;
  int            edge_no = 0;
  int            max_count = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  typedef struct {
    bit            ov;
    bit            rdy;
    logic [DW-1:0] z;
    logic [DW-1:0] x;
    bit            e_valid;
    int            e_count;
    logic [DW-1:0] e_z;
    logic [DW-1:0] e_x;
  } vec_t;

  vec_t tbl[10];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_no, act, exp);
    end
  endfunction

  function automatic void check_model();
    logic [DW-1:0] ez, ex;
    ez = '0;
    ex = '0;
    if (mz.size() != 0) begin
      ez = mz[0];
      ex = mx[0];
    end
    chk("out_valid", 64'(out_valid), 64'(mz.size() != 0));
    chk("count", 64'(count), 64'(mz.size()));
    chk("empty", 64'(empty), 64'(mz.size() == 0));
    chk("full", 64'(full), 64'(mz.size() == DEPTH));
    chk("z_out", 64'(z_out), 64'(ez));
    chk("x_out", 64'(x_out), 64'(ex));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    if (int'(count) > max_count) max_count = int'(count);
  endfunction

  // One clock: ov issues an operand set whose results will be (oz, ox) LAT edges later.
  task automatic cycle(input bit rst, input bit ov, input bit rdy,
                       input logic [DW-1:0] oz, input logic [DW-1:0] ox);
    int  n;
    bit  cap, pop;
    op_t o;
    n = edge_no + 1;
    Reset     = rst;
    op_valid  = ov;
    out_ready = rdy;
    if (due.size() > 0 && due[0].e == n) begin
      z_in = due[0].z;
      x_in = due[0].x;
    end else begin
      z_in = $urandom;
      x_in = $urandom;
    end
    @(posedge Clk);
    edge_no = n;
    if (rst) begin
      due.delete();
      mz.delete();
      mx.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      pop = (mz.size() > 0) && rdy;
      cap = (due.size() > 0 && due[0].e == n);
      if (pop) begin
        void'(mz.pop_front());
        void'(mx.pop_front());
      end
      if (cap) begin
        o = due.pop_front();
        if (mz.size() < DEPTH) begin
          mz.push_back(o.z);
          mx.push_back(o.x);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (ov) due.push_back('{n + int'(LAT), oz, ox});
    end
    #1;
    check_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_z;
    int            nxt;

    tbl[0] = '{1'b1, 1'b1, 5,  7,  1'b0, 0, 0,  0};
    tbl[1] = '{1'b0, 1'b1, 0,  0,  1'b0, 0, 0,  0};
    tbl[2] = '{1'b0, 1'b1, 0,  0,  1'b1, 1, 5,  7};
    tbl[3] = '{1'b0, 1'b1, 0,  0,  1'b0, 0, 0,  0};
    tbl[4] = '{1'b1, 1'b0, 11, 12, 1'b0, 0, 0,  0};
    tbl[5] = '{1'b1, 1'b0, 13, 14, 1'b0, 0, 0,  0};
    tbl[6] = '{1'b0, 1'b0, 0,  0,  1'b1, 1, 11, 12};
    tbl[7] = '{1'b0, 1'b0, 0,  0,  1'b1, 2, 11, 12};
    tbl[8] = '{1'b0, 1'b1, 0,  0,  1'b1, 1, 13, 14};
    tbl[9] = '{1'b0, 1'b1, 0,  0,  1'b0, 0, 0,  0};

    // Reset held for two cycles
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z_out", 64'(z_out), 64'd0);
    chk("rst_x_out", 64'(x_out), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Single pulse and a short back-to-back pair
    for (int i = 0; i < 10; i++) begin
      cycle(0, tbl[i].ov, tbl[i].rdy, tbl[i].z, tbl[i].x);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_count));
      chk($sformatf("tbl%0d_z", i), 64'(z_out), 64'(tbl[i].e_z));
      chk($sformatf("tbl%0d_x", i), 64'(x_out), 64'(tbl[i].e_x));
    end

    // Fill to full, ninth capture is dropped, then drain in order
    for (int k = 1; k <= 9; k++) cycle(0, 1, 0, DW'(k), DW'(k + 100));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd8);
    chk("drop_overflow", 64'(overflow), 64'd1);
    chk("drop_cnt_one", 64'(drop_cnt), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      chk("drain_z", 64'(z_out), 64'(k));
      chk("drain_x", 64'(x_out), 64'(k + 100));
      cycle(0, 0, 1, 0, 0);
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Full FIFO: capture and pop on the same edge
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) cycle(0, 1, 0, DW'(k), DW'(k + 100));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("pp_full_before", 64'(full), 64'd1);
    cycle(0, 1, 0, 10, 110);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("pp_count", 64'(count), 64'd8);
    chk("pp_no_drop", 64'(drop_cnt), 64'd0);
    chk("pp_no_overflow", 64'(overflow), 64'd0);
    for (int k = 0; k < 8; k++) begin
      exp_z = (k < 7) ? DW'(k + 2) : DW'(10);
      chk("pp_order", 64'(z_out), 64'(exp_z));
      cycle(0, 0, 1, 0, 0);
    end
    chk("pp_empty", 64'(empty), 64'd1);

    // Twenty captures with toggling ready, crossing pointer wrap
    cycle(1, 0, 0, 0, 0);
    max_count = 0;
    nxt = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid && (i % 2 == 0)) begin
        chk("wrap_order", 64'(z_out), 64'(200 + nxt));
        nxt++;
      end
      cycle(0, (i < 40) && (i % 2 == 0), (i % 2 == 0), DW'(200 + i / 2), DW'(i));
    end
    chk("wrap_all_out", 64'(nxt), 64'd20);
    chk("wrap_max_count", 64'(max_count <= 8), 64'd1);
    chk("wrap_no_drop", 64'(drop_cnt), 64'd0);

    // Randomised traffic: congested first, then mostly draining
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cycle(0, bit'($urandom_range(0, 1)),
            (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom, $urandom);
    end

    // Reset with stored entries and operand sets still in flight
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 1, 0, DW'(300 + k), DW'(k));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 400, 1);
    cycle(0, 1, 0, 401, 2);
    chk("pre_reset_count", 64'(count), 64'd5);
    cycle(1, 0, 0, 0, 0);
    chk("mid_reset_count", 64'(count), 64'd0);
    chk("mid_reset_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1, 0, 0);
      chk("no_inflight_out", 64'(out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
